// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, default buffer depth and the
// transmit handshake state encoding.
package uart_pkg;

  localparam int UART_DATA_W    = 8;
  localparam int BUF_DEPTH_LOG2 = 4;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/uart_tx_buffer_fifo_sync.sv
// Synchronous byte FIFO: storage, wrapping pointers, occupancy count and
// full/empty flags decoded from the count register.
module fifo_sync
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = BUF_DEPTH_LOG2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [UART_DATA_W-1:0] wr_data,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic [DEPTH_LOG2:0]    count,
  output logic                   full,
  output logic                   empty
);

  localparam logic [DEPTH_LOG2:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [UART_DATA_W-1:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0]  wr_ptr;
  logic [DEPTH_LOG2-1:0]  rd_ptr;
  logic                   do_push;
  logic                   do_pop;

  // Full is judged before this cycle's pop, so a full FIFO never accepts a write.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign full    = (count == DEPTH);
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte buffer in front of the UART transmitter: FIFO plus WAIT/SEND/GAP
// handshake that offers one byte per transmitter idle period, and a sticky overflow flag.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = BUF_DEPTH_LOG2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   WR_EN,
  input  logic [UART_DATA_W-1:0] WR_DATA,
  input  logic                   FLUSH,
  output logic                   FULL,
  output logic                   EMPTY,
  output logic [DEPTH_LOG2:0]    COUNT,
  output logic                   OVERFLOW,
  input  logic                   OVF_CLR,
  output logic [UART_DATA_W-1:0] TX_DATA,
  output logic                   TX_READY,
  input  logic                   TX_IDLE
);

  tx_state_t              state;
  tx_state_t              state_next;
  logic                   pop;
  logic [UART_DATA_W-1:0] head;

  fifo_sync #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push    (WR_EN),
    .pop     (pop),
    .flush   (FLUSH),
    .wr_data (WR_DATA),
    .rd_data (head),
    .count   (COUNT),
    .full    (FULL),
    .empty   (EMPTY)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_WAIT;
    else     state <= state_next;
  end

  // GAP gives the transmitter one cycle to drop TX_IDLE before it is looked at again.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      ST_WAIT: begin
        if (!FLUSH && !EMPTY && TX_IDLE) begin
          pop        = 1'b1;
          state_next = ST_SEND;
        end
      end
      ST_SEND: state_next = ST_GAP;
      ST_GAP:  state_next = ST_WAIT;
      default: state_next = ST_WAIT;
    endcase
  end

  assign TX_READY = (state == ST_SEND);

  always_ff @(posedge CLK) begin
    if (RST)      TX_DATA <= '0;
    else if (pop) TX_DATA <= head;
  end

  // A new overflow outranks a clear arriving in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST)               OVERFLOW <= 1'b0;
    else if (WR_EN && FULL) OVERFLOW <= 1'b1;
    else if (OVF_CLR)      OVERFLOW <= 1'b0;
  end

endmodule
